// File: rtl/ctrl_unit_p_if.sv
// Signal bundle between the ctrl_unit_p sequencer (master) and the datapath/memory (slave).
// mem_rd/mem_wr form a request held high through the first cycle mem_ready is seen; that cycle completes the access.
interface ctrl_unit_p_if #(
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS + 1)
);
    logic [7:0]          ir;
    logic [3:0]          ccr;
    logic                mem_ready;
    logic                ir_load;
    logic                mar_load;
    logic                pc_load;
    logic                pc_inc;
    logic                ccr_load;
    logic [NUM_REGS-1:0] reg_load;
    logic [2:0]          alu_sel;
    logic [SEL_W-1:0]    bus1_sel;
    logic [1:0]          bus2_sel;
    logic                mem_rd;
    logic                mem_wr;
    logic                illegal_op;
    logic                bus_error;
    logic                halted;
    logic [2:0]          state_dbg;

    modport master (
        input  ir, ccr, mem_ready,
        output ir_load, mar_load, pc_load, pc_inc, ccr_load, reg_load, alu_sel,
               bus1_sel, bus2_sel, mem_rd, mem_wr, illegal_op, bus_error, halted, state_dbg
    );

    modport slave (
        output ir, ccr, mem_ready,
        input  ir_load, mar_load, pc_load, pc_inc, ccr_load, reg_load, alu_sel,
               bus1_sel, bus2_sel, mem_rd, mem_wr, illegal_op, bus_error, halted, state_dbg
    );
endinterface

// File: rtl/ctrl_unit_p.sv
// Instruction sequencer for the 8-bit microcontroller: fetch/decode/execute FSM with
// a stalling memory handshake, wait-timeout bus errors, HALT and illegal-opcode reporting.
module ctrl_unit_p #(
    parameter int NUM_REGS   = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic          clk,
    input  logic          reset,
    ctrl_unit_p_if.master bus
);
    localparam int SEL_W = $clog2(NUM_REGS + 1);
    localparam int CNT_W = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

    typedef enum logic [2:0] {
        FETCH0 = 3'd0, FETCH1 = 3'd1, DECODE = 3'd2, OPND0 = 3'd3,
        OPND1  = 3'd4, MEMX   = 3'd5, EXEC   = 3'd6, HALT  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ALU, OP_BR, OP_HALT, OP_ILL
    } op_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    op_t              op;
    logic [1:0]       d;
    logic             reg_ok;
    logic             br_cond, br_take;
    logic             wait_st, timeout;

    assign d         = bus.ir[1:0];
    assign reg_ok    = int'(d) < NUM_REGS;
    assign wait_st   = (state_q == FETCH1) || (state_q == OPND1) || (state_q == MEMX);
    assign timeout   = (WAIT_LIMIT > 0) && wait_st && !bus.mem_ready &&
                       (cnt_q == CNT_W'(WAIT_LIMIT));
    assign bus.state_dbg = state_q;

    always_comb begin
        op = OP_ILL;
        if (bus.ir == 8'h00)                                op = OP_NOP;
        else if (bus.ir == 8'hF0)                           op = OP_HALT;
        else if (bus.ir[7:4] == 4'h4)                       op = OP_ALU;
        else if (bus.ir[7:4] == 4'h5 && bus.ir[2:0] <= 3'd4) op = OP_BR;
        else if (bus.ir[7:2] == 6'b000100 && reg_ok)        op = OP_LDI;
        else if (bus.ir[7:2] == 6'b001000 && reg_ok)        op = OP_LD;
        else if (bus.ir[7:2] == 6'b001100 && reg_ok)        op = OP_ST;
    end

    // ir[2:0] picks the flag, ir[3] inverts it (so 0x58 never branches).
    always_comb begin
        case (bus.ir[2:0])
            3'd1:    br_cond = bus.ccr[3];
            3'd2:    br_cond = bus.ccr[2];
            3'd3:    br_cond = bus.ccr[1];
            3'd4:    br_cond = bus.ccr[0];
            default: br_cond = 1'b1;
        endcase
        br_take = br_cond ^ bus.ir[3];
    end

    // The wait counter only runs while a request is stalled; any other cycle clears it.
    always_comb begin
        cnt_d = '0;
        if (wait_st && !bus.mem_ready && !timeout && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        bus.ir_load    = 1'b0;
        bus.mar_load   = 1'b0;
        bus.pc_load    = 1'b0;
        bus.pc_inc     = 1'b0;
        bus.ccr_load   = 1'b0;
        bus.reg_load   = '0;
        bus.alu_sel    = 3'd0;
        bus.bus1_sel   = '0;
        bus.bus2_sel   = 2'd0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.illegal_op = 1'b0;
        bus.bus_error  = 1'b0;
        bus.halted     = 1'b0;
        // Outputs are forced quiet while reset is low so an in-flight write is aborted at once.
        if (reset) begin
            case (state_q)
                FETCH0, OPND0: begin
                    bus.bus2_sel = 2'd1;
                    bus.mar_load = 1'b1;
                    bus.pc_inc   = 1'b1;
                    state_d      = (state_q == FETCH0) ? FETCH1 : OPND1;
                end
                FETCH1: begin
                    bus.mem_rd = !timeout;
                    if (bus.mem_ready) begin
                        bus.bus2_sel = 2'd2;
                        bus.ir_load  = 1'b1;
                        state_d      = DECODE;
                    end else if (timeout) begin
                        state_d = HALT;
                    end
                end
                DECODE: begin
                    case (op)
                        OP_NOP:  state_d = FETCH0;
                        OP_ALU:  state_d = EXEC;
                        OP_HALT: state_d = HALT;
                        OP_ILL: begin
                            bus.illegal_op = 1'b1;
                            state_d        = FETCH0;
                        end
                        default: state_d = OPND0;
                    endcase
                end
                OPND1: begin
                    bus.mem_rd = !timeout;
                    if (bus.mem_ready) begin
                        bus.bus2_sel = 2'd2;
                        state_d      = FETCH0;
                        case (op)
                            OP_LDI:  bus.reg_load = NUM_REGS'(1) << d;
                            OP_BR:   bus.pc_load  = br_take;
                            default: begin
                                bus.mar_load = 1'b1;
                                state_d      = MEMX;
                            end
                        endcase
                    end else if (timeout) begin
                        state_d = HALT;
                    end
                end
                MEMX: begin
                    if (op == OP_ST) begin
                        bus.bus1_sel = SEL_W'(d) + SEL_W'(1);
                        bus.mem_wr   = !timeout;
                    end else begin
                        bus.mem_rd = !timeout;
                        if (bus.mem_ready) begin
                            bus.bus2_sel = 2'd2;
                            bus.reg_load = NUM_REGS'(1) << d;
                        end
                    end
                    if (bus.mem_ready)  state_d = FETCH0;
                    else if (timeout)   state_d = HALT;
                end
                EXEC: begin
                    bus.bus1_sel = SEL_W'(bus.ir[3]) + SEL_W'(1);
                    bus.alu_sel  = bus.ir[2:0];
                    bus.reg_load = NUM_REGS'(1) << bus.ir[3];
                    bus.ccr_load = 1'b1;
                    state_d      = FETCH0;
                end
                default: ;
            endcase
            bus.bus_error = timeout;
            bus.halted    = (state_q == HALT);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ctrl_unit_p.sv
// Directed bench for ctrl_unit_p: a 4-register/4-cycle-timeout instance and a
// 2-register/no-timeout instance, checked cycle by cycle against hand-computed values.
module tb_ctrl_unit_p;
    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    ctrl_unit_p_if #(.NUM_REGS(4)) bus_a ();
    ctrl_unit_p_if #(.NUM_REGS(2)) bus_b ();

    ctrl_unit_p #(.NUM_REGS(4), .WAIT_LIMIT(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    ctrl_unit_p #(.NUM_REGS(2), .WAIT_LIMIT(0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    // Strobe bit positions in the packed strobe word.
    localparam logic [9:0] S_IRL = 10'h001, S_MAR = 10'h002, S_PCL = 10'h004, S_PCI = 10'h008,
                           S_CCR = 10'h010, S_RD  = 10'h020, S_WR  = 10'h040, S_ILL = 10'h080,
                           S_BERR = 10'h100, S_HLT = 10'h200;
    localparam logic [2:0] F0 = 3'd0, F1 = 3'd1, DC = 3'd2, O0 = 3'd3,
                           O1 = 3'd4, MX = 3'd5, EX = 3'd6, HL = 3'd7;

    int n_cmp = 0;
    int n_err = 0;
    logic [9:0] exp_q[$];

    logic [7:0] br_op   [9] = '{8'h52, 8'h52, 8'h58, 8'h58, 8'h5C, 8'h51, 8'h53, 8'h50, 8'h5A};
    logic [3:0] br_ccr  [9] = '{4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b1000, 4'b0010, 4'b0000, 4'b0100};
    logic       br_take [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [2:0] st, input logic [9:0] s,
                         input logic [3:0] rl, input logic [2:0] b1, input logic [1:0] b2,
                         input logic [2:0] alu);
        logic [9:0] got_s;
        #1;
        got_s = {bus_a.halted, bus_a.bus_error, bus_a.illegal_op, bus_a.mem_wr, bus_a.mem_rd,
                 bus_a.ccr_load, bus_a.pc_inc, bus_a.pc_load, bus_a.mar_load, bus_a.ir_load};
        check({tag, ".state"},   32'(bus_a.state_dbg), 32'(st));
        check({tag, ".strobes"}, 32'(got_s),           32'(s));
        check({tag, ".reg_load"}, 32'(bus_a.reg_load), 32'(rl));
        check({tag, ".bus1_sel"}, 32'(bus_a.bus1_sel), 32'(b1));
        check({tag, ".bus2_sel"}, 32'(bus_a.bus2_sel), 32'(b2));
        check({tag, ".alu_sel"},  32'(bus_a.alu_sel),  32'(alu));
    endtask

    task automatic chk_b(input string tag, input logic [2:0] st, input logic [9:0] s,
                         input logic [1:0] rl, input logic [1:0] b1, input logic [1:0] b2);
        logic [9:0] got_s;
        #1;
        got_s = {bus_b.halted, bus_b.bus_error, bus_b.illegal_op, bus_b.mem_wr, bus_b.mem_rd,
                 bus_b.ccr_load, bus_b.pc_inc, bus_b.pc_load, bus_b.mar_load, bus_b.ir_load};
        check({tag, ".state"},    32'(bus_b.state_dbg), 32'(st));
        check({tag, ".strobes"},  32'(got_s),           32'(s));
        check({tag, ".reg_load"}, 32'(bus_b.reg_load),  32'(rl));
        check({tag, ".bus1_sel"}, 32'(bus_b.bus1_sel),  32'(b1));
        check({tag, ".bus2_sel"}, 32'(bus_b.bus2_sel),  32'(b2));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic next_a(input logic rdy);
        step();
        bus_a.mem_ready = rdy;
    endtask

    // Starts in a FETCH0 cycle, ends positioned in the DECODE cycle.
    task automatic fetch_a(input logic [7:0] op, input string tag);
        bus_a.ir        = op;
        bus_a.mem_ready = 1'b1;
        chk_a({tag, ".f0"}, F0, S_MAR | S_PCI, 4'h0, 3'd0, 2'd1, 3'd0);
        next_a(1'b1);
        chk_a({tag, ".f1"}, F1, S_RD | S_IRL, 4'h0, 3'd0, 2'd2, 3'd0);
        next_a(1'b1);
    endtask

    // Fetch, decode and operand-address cycle; ends positioned in OPND0.
    task automatic lead_a(input logic [7:0] op, input string tag);
        fetch_a(op, tag);
        chk_a({tag, ".dec"}, DC, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        chk_a({tag, ".o0"}, O0, S_MAR | S_PCI, 4'h0, 3'd0, 2'd1, 3'd0);
    endtask

    task automatic fetch_b(input logic [7:0] op, input string tag);
        bus_b.ir        = op;
        bus_b.mem_ready = 1'b1;
        chk_b({tag, ".f0"}, F0, S_MAR | S_PCI, 2'd0, 2'd0, 2'd1);
        step();
        chk_b({tag, ".f1"}, F1, S_RD | S_IRL, 2'd0, 2'd0, 2'd2);
        step();
    endtask

    task automatic ill_b(input logic [7:0] op, input string tag);
        fetch_b(op, tag);
        chk_b({tag, ".dec"}, DC, S_ILL, 2'd0, 2'd0, 2'd0);
        step();
    endtask

    initial begin
        bus_a.ir = 8'h00; bus_a.ccr = 4'h0; bus_a.mem_ready = 1'b0;
        bus_b.ir = 8'h00; bus_b.ccr = 4'h0; bus_b.mem_ready = 1'b0;

        // Reset: quiet outputs even with mem_ready high.
        repeat (2) @(posedge clk);
        #1;
        chk_a("rst", F0, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        bus_a.mem_ready = 1'b1;
        chk_a("rst_rdy", F0, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        reset = 1'b1;

        // LDI r2,#0x5A: register write in cycle 5, FETCH0 in cycle 6.
        lead_a(8'h12, "ldi");
        next_a(1'b1);
        chk_a("ldi.o1", O1, S_RD, 4'b0100, 3'd0, 2'd2, 3'd0);
        next_a(1'b1);

        // ST r3,[0x80] with three stall cycles in MEMX.
        lead_a(8'h33, "st");
        next_a(1'b1);
        chk_a("st.o1", O1, S_RD | S_MAR, 4'h0, 3'd0, 2'd2, 3'd0);
        next_a(1'b0);
        for (int i = 0; i < 3; i++) begin
            chk_a($sformatf("st.stall%0d", i), MX, S_WR, 4'h0, 3'd4, 2'd0, 3'd0);
            next_a(i == 2);
        end
        chk_a("st.done", MX, S_WR, 4'h0, 3'd4, 2'd0, 3'd0);
        next_a(1'b1);

        // ALU 0x4B: dest r1, alu_sel 3.
        fetch_a(8'h4B, "alu");
        chk_a("alu.dec", DC, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        chk_a("alu.ex", EX, S_CCR, 4'b0010, 3'd2, 2'd0, 3'd3);
        next_a(1'b1);

        // Branch condition table.
        for (int i = 0; i < 9; i++) begin
            bus_a.ccr = br_ccr[i];
            exp_q.push_back(br_take[i] ? (S_RD | S_PCL) : S_RD);
            lead_a(br_op[i], $sformatf("br%0d", i));
            next_a(1'b1);
            chk_a($sformatf("br%0d.o1", i), O1, exp_q.pop_front(), 4'h0, 3'd0, 2'd2, 3'd0);
            next_a(1'b1);
        end

        // Taken branch with one operand stall: no pc_load until mem_ready.
        bus_a.ccr = 4'b0100;
        lead_a(8'h52, "brs");
        next_a(1'b0);
        chk_a("brs.stall", O1, S_RD, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        chk_a("brs.rdy", O1, S_RD | S_PCL, 4'h0, 3'd0, 2'd2, 3'd0);
        next_a(1'b1);

        // LD r1 with an operand stall.
        lead_a(8'h21, "ld");
        next_a(1'b0);
        chk_a("ld.stall", O1, S_RD, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        chk_a("ld.o1", O1, S_RD | S_MAR, 4'h0, 3'd0, 2'd2, 3'd0);
        next_a(1'b1);
        chk_a("ld.mx", MX, S_RD, 4'b0010, 3'd0, 2'd2, 3'd0);
        next_a(1'b1);

        // NOP and illegal opcodes.
        fetch_a(8'h00, "nop");
        chk_a("nop.dec", DC, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        fetch_a(8'h77, "ill77");
        chk_a("ill77.dec", DC, S_ILL, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        fetch_a(8'h55, "ill55");
        chk_a("ill55.dec", DC, S_ILL, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        fetch_a(8'h34, "ill34");
        chk_a("ill34.dec", DC, S_ILL, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);

        // mem_ready arriving exactly at the wait limit is a success.
        bus_a.ir = 8'h00;
        chk_a("lim.f0", F0, S_MAR | S_PCI, 4'h0, 3'd0, 2'd1, 3'd0);
        next_a(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_a($sformatf("lim.stall%0d", i), F1, S_RD, 4'h0, 3'd0, 2'd0, 3'd0);
            next_a(i == 3);
        end
        chk_a("lim.ok", F1, S_RD | S_IRL, 4'h0, 3'd0, 2'd2, 3'd0);
        next_a(1'b1);
        chk_a("lim.dec", DC, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);

        // Timeout: four stalls, then bus_error, then HALT.
        chk_a("to.f0", F0, S_MAR | S_PCI, 4'h0, 3'd0, 2'd1, 3'd0);
        next_a(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_a($sformatf("to.stall%0d", i), F1, S_RD, 4'h0, 3'd0, 2'd0, 3'd0);
            next_a(1'b0);
        end
        chk_a("to.err", F1, S_BERR, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b0);
        chk_a("to.halt0", HL, S_HLT, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        chk_a("to.halt1", HL, S_HLT, 4'h0, 3'd0, 2'd0, 3'd0);
        reset = 1'b0;
        chk_a("to.rst", F0, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        step();
        reset = 1'b1;

        // Reset during a stalled write aborts mem_wr.
        lead_a(8'h30, "stab");
        next_a(1'b1);
        chk_a("stab.o1", O1, S_RD | S_MAR, 4'h0, 3'd0, 2'd2, 3'd0);
        next_a(1'b0);
        chk_a("stab.mx", MX, S_WR, 4'h0, 3'd1, 2'd0, 3'd0);
        reset = 1'b0;
        chk_a("stab.rst", F0, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        step();
        reset = 1'b1;

        // ALU into r0, then HALT holds until reset.
        fetch_a(8'h40, "alu0");
        chk_a("alu0.dec", DC, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        chk_a("alu0.ex", EX, S_CCR, 4'b0001, 3'd1, 2'd0, 3'd0);
        next_a(1'b1);
        fetch_a(8'hF0, "hlt");
        chk_a("hlt.dec", DC, 10'h0, 4'h0, 3'd0, 2'd0, 3'd0);
        next_a(1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_a($sformatf("hlt.hold%0d", i), HL, S_HLT, 4'h0, 3'd0, 2'd0, 3'd0);
            next_a(i[0]);
        end

        // Second instance has been stalled in FETCH1 since reset with no timeout.
        chk_b("b.nto", F1, S_RD, 2'd0, 2'd0, 2'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;

        ill_b(8'h13, "b.ill13");
        ill_b(8'h12, "b.ill12");
        ill_b(8'h77, "b.ill77");
        fetch_b(8'h11, "b.ldi");
        chk_b("b.ldi.dec", DC, 10'h0, 2'd0, 2'd0, 2'd0);
        step();
        chk_b("b.ldi.o0", O0, S_MAR | S_PCI, 2'd0, 2'd0, 2'd1);
        step();
        chk_b("b.ldi.o1", O1, S_RD, 2'b10, 2'd0, 2'd2);
        step();
        fetch_b(8'h31, "b.st");
        step();
        step();
        chk_b("b.st.o1", O1, S_RD | S_MAR, 2'd0, 2'd0, 2'd2);
        step();
        chk_b("b.st.mx", MX, S_WR, 2'd0, 2'd2, 2'd0);
        step();
        chk_b("b.st.f0", F0, S_MAR | S_PCI, 2'd0, 2'd0, 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
